// File: rtl/ace_pkg.sv
// Core-wide sizing and ROB entry layout shared by dispatch, the RS/LSQ and the ROB.
package ace_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int LSQ_DEPTH = 16;
  localparam int RS0_DEPTH = 16;
  localparam int RS1_DEPTH = 16;

  // ROB entry payload: LSB offset of each field within the dispatch word
  localparam int ROB_PC_LSB   = 0;
  localparam int ROB_PC_W     = 21;
  localparam int ROB_RD_LSB   = 21;
  localparam int ROB_RS2_LSB  = 28;
  localparam int ROB_RS1_LSB  = 35;
  localparam int ROB_PREG_W   = 7;
  localparam int ROB_LD       = 42;
  localparam int ROB_ST       = 43;
  localparam int ROB_CSR      = 44;
  localparam int ROB_SYSCALL  = 45;
  localparam int ROB_RET      = 46;
  localparam int ROB_VLD      = 47;
  localparam int ROB_ENTRY_W  = 48;
endpackage

// File: rtl/ace_rob_retire_sel.sv
// Leading-done scan over the four entries at the ROB head; purely combinational.
// Stops at the first entry that is not valid+done+clean, or at the occupancy limit.
module ace_rob_retire_sel #(
  parameter int CNT_W = 6
) (
  input  logic [3:0]       vld,
  input  logic [3:0]       done,
  input  logic [3:0]       exc,
  input  logic [CNT_W-1:0] occ,
  output logic [2:0]       ret_n,
  output logic [3:0]       ret_vld,
  output logic             head_exc
);
  logic run;

  always_comb begin
    ret_n   = '0;
    ret_vld = '0;
    run     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (run && vld[k] && done[k] && !exc[k] && (CNT_W'(k) < occ)) begin
        ret_vld[k] = 1'b1;
        ret_n      = ret_n + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
    head_exc = vld[0] & done[0] & exc[0];
  end
endmodule

// File: rtl/ace_rob.sv
// Reorder buffer: 4-wide in-order allocate, two completion ports, 4-wide in-order retire.
// Alloc ids are combinational; retire, exception and occupancy outputs are registered.
module ace_rob #(
  parameter int ROB_DEPTH = ace_pkg::ROB_DEPTH,
  parameter int ENTRY_W   = ace_pkg::ROB_ENTRY_W,
  parameter int ID_W      = $clog2(ROB_DEPTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [3:0]         dispatch_vld_i,
  input  logic [ENTRY_W-1:0] dispatch_rob_wdata0_i,
  input  logic [ENTRY_W-1:0] dispatch_rob_wdata1_i,
  input  logic [ENTRY_W-1:0] dispatch_rob_wdata2_i,
  input  logic [ENTRY_W-1:0] dispatch_rob_wdata3_i,
  output logic [ID_W-1:0]    rob_alloc_id0_o,
  output logic [ID_W-1:0]    rob_alloc_id1_o,
  output logic [ID_W-1:0]    rob_alloc_id2_o,
  output logic [ID_W-1:0]    rob_alloc_id3_o,
  input  logic               complete_vld0_i,
  input  logic               complete_vld1_i,
  input  logic [ID_W-1:0]    complete_id0_i,
  input  logic [ID_W-1:0]    complete_id1_i,
  input  logic               complete_exc0_i,
  input  logic               complete_exc1_i,
  input  logic               flush_i,
  output logic [3:0]         retire_vld_o,
  output logic [ENTRY_W-1:0] retire_data0_o,
  output logic [ENTRY_W-1:0] retire_data1_o,
  output logic [ENTRY_W-1:0] retire_data2_o,
  output logic [ENTRY_W-1:0] retire_data3_o,
  output logic               rob_exc_o,
  output logic [ID_W-1:0]    rob_exc_id_o,
  output logic [ID_W:0]      retire_rob_cnt_o
);
  import ace_pkg::*;

  localparam int CW = ID_W + 1;

  logic [CW-1:0]        head, tail, occ;
  logic [ROB_DEPTH-1:0] ent_vld, ent_done, ent_exc;
  logic [ENTRY_W-1:0]   ent_dat [ROB_DEPTH];
  logic [ENTRY_W-1:0]   wdat [4];
  logic [ID_W-1:0]      alloc_id [4];
  logic [ID_W-1:0]      win_idx [4];
  logic [3:0]           win_vld, win_done, win_exc, ret_vld;
  logic [2:0]           alloc_n, ret_n;
  logic [CW-1:0]        alloc_add, ret_sub;
  logic                 alloc_ok, head_exc, clear, same_id;

  assign occ     = tail - head;
  assign wdat[0] = dispatch_rob_wdata0_i;
  assign wdat[1] = dispatch_rob_wdata1_i;
  assign wdat[2] = dispatch_rob_wdata2_i;
  assign wdat[3] = dispatch_rob_wdata3_i;

  always_comb begin
    alloc_n = '0;
    for (int k = 0; k < 4; k++) begin
      alloc_id[k] = tail[ID_W-1:0] + ID_W'(alloc_n);
      alloc_n     = alloc_n + {2'b00, dispatch_vld_i[k]};
    end
  end

  // Judged against pre-retire occupancy: the same figure dispatch stalls on
  assign alloc_ok = ({1'b0, occ} + {{(CW-2){1'b0}}, alloc_n}) <= (CW+1)'(ROB_DEPTH);

  assign rob_alloc_id0_o = alloc_id[0];
  assign rob_alloc_id1_o = alloc_id[1];
  assign rob_alloc_id2_o = alloc_id[2];
  assign rob_alloc_id3_o = alloc_id[3];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      win_idx[k]  = head[ID_W-1:0] + ID_W'(k);
      win_vld[k]  = ent_vld[win_idx[k]];
      win_done[k] = ent_done[win_idx[k]];
      win_exc[k]  = ent_exc[win_idx[k]];
    end
  end

  ace_rob_retire_sel #(.CNT_W(CW)) u_retire_sel (
    .vld      (win_vld),
    .done     (win_done),
    .exc      (win_exc),
    .occ      (occ),
    .ret_n    (ret_n),
    .ret_vld  (ret_vld),
    .head_exc (head_exc)
  );

  assign clear     = flush_i | head_exc;
  assign same_id   = complete_id0_i == complete_id1_i;
  assign alloc_add = alloc_ok ? {{(CW-3){1'b0}}, alloc_n} : '0;
  assign ret_sub   = {{(CW-3){1'b0}}, ret_n};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head             <= '0;
      tail             <= '0;
      ent_vld          <= '0;
      ent_done         <= '0;
      ent_exc          <= '0;
      retire_vld_o     <= '0;
      retire_data0_o   <= '0;
      retire_data1_o   <= '0;
      retire_data2_o   <= '0;
      retire_data3_o   <= '0;
      rob_exc_o        <= 1'b0;
      rob_exc_id_o     <= '0;
      retire_rob_cnt_o <= '0;
    end else if (clear) begin
      head             <= '0;
      tail             <= '0;
      ent_vld          <= '0;
      ent_done         <= '0;
      ent_exc          <= '0;
      retire_vld_o     <= '0;
      retire_rob_cnt_o <= '0;
      rob_exc_o        <= !flush_i;
      if (!flush_i) rob_exc_id_o <= head[ID_W-1:0];
    end else begin
      rob_exc_o <= 1'b0;
      if (complete_vld0_i && ent_vld[complete_id0_i]) begin
        ent_done[complete_id0_i] <= 1'b1;
        ent_exc[complete_id0_i]  <= complete_exc0_i | (same_id & complete_vld1_i & complete_exc1_i);
      end
      if (complete_vld1_i && ent_vld[complete_id1_i]) begin
        ent_done[complete_id1_i] <= 1'b1;
        ent_exc[complete_id1_i]  <= complete_exc1_i | (same_id & complete_vld0_i & complete_exc0_i);
      end
      for (int k = 0; k < 4; k++) begin
        if (ret_vld[k]) begin
          ent_vld[win_idx[k]]  <= 1'b0;
          ent_done[win_idx[k]] <= 1'b0;
          ent_exc[win_idx[k]]  <= 1'b0;
        end
      end
      if (alloc_ok) begin
        for (int k = 0; k < 4; k++) begin
          if (dispatch_vld_i[k]) begin
            ent_vld[alloc_id[k]]  <= 1'b1;
            ent_done[alloc_id[k]] <= 1'b0;
            ent_exc[alloc_id[k]]  <= 1'b0;
          end
        end
      end
      head             <= head + ret_sub;
      tail             <= tail + alloc_add;
      retire_vld_o     <= ret_vld;
      retire_data0_o   <= ent_dat[win_idx[0]];
      retire_data1_o   <= ent_dat[win_idx[1]];
      retire_data2_o   <= ent_dat[win_idx[2]];
      retire_data3_o   <= ent_dat[win_idx[3]];
      retire_rob_cnt_o <= occ + alloc_add - ret_sub;
    end
  end

  always_ff @(posedge clock) begin
    if (alloc_ok && !clear) begin
      for (int k = 0; k < 4; k++) begin
        if (dispatch_vld_i[k]) ent_dat[alloc_id[k]] <= wdat[k];
      end
    end
  end

  overflow_chk: assert property (@(posedge clock) disable iff (!reset_n) (flush_i || alloc_ok));
endmodule

// File: tb/tb_ace_rob.sv
// Bench for ace_rob: table of per-cycle vectors, retire payload scoreboard, wrap-around sequences.
module tb_ace_rob;
  localparam int ID_W = 5;
  localparam int EW   = 48;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [3:0]      dispatch_vld;
  logic [EW-1:0]   wd [4];
  logic [ID_W-1:0] aid0, aid1, aid2, aid3;
  logic            cv0, cv1, ce0, ce1, flush;
  logic [ID_W-1:0] ci0, ci1;
  logic [3:0]      retire_vld;
  logic [EW-1:0]   rd0, rd1, rd2, rd3;
  logic            rob_exc;
  logic [ID_W-1:0] rob_exc_id;
  logic [ID_W:0]   rob_cnt;

  ace_rob dut (
    .clock(clock), .reset_n(reset_n), .dispatch_vld_i(dispatch_vld),
    .dispatch_rob_wdata0_i(wd[0]), .dispatch_rob_wdata1_i(wd[1]),
    .dispatch_rob_wdata2_i(wd[2]), .dispatch_rob_wdata3_i(wd[3]),
    .rob_alloc_id0_o(aid0), .rob_alloc_id1_o(aid1), .rob_alloc_id2_o(aid2), .rob_alloc_id3_o(aid3),
    .complete_vld0_i(cv0), .complete_vld1_i(cv1), .complete_id0_i(ci0), .complete_id1_i(ci1),
    .complete_exc0_i(ce0), .complete_exc1_i(ce1), .flush_i(flush),
    .retire_vld_o(retire_vld), .retire_data0_o(rd0), .retire_data1_o(rd1),
    .retire_data2_o(rd2), .retire_data3_o(rd3), .rob_exc_o(rob_exc),
    .rob_exc_id_o(rob_exc_id), .retire_rob_cnt_o(rob_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic            rst;
    logic [3:0]      dv;
    logic            cv0; logic [ID_W-1:0] ci0; logic ce0;
    logic            cv1; logic [ID_W-1:0] ci1; logic ce1;
    logic            fl;
    logic [ID_W-1:0] id0, id1, id2, id3;
    logic [3:0]      ret;
    logic [ID_W:0]   cnt;
    logic            exc;
    logic [ID_W-1:0] exc_id;
  } vec_t;

  localparam int NV = 17;
  vec_t          tbl [NV];
  logic [EW-1:0] sb [$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            seq = 0;
  int            tail_m, nc;

  function automatic vec_t mk(int rst, int dv, int a0, int i0, int e0, int a1, int i1, int e1,
                              int fl, int x0, int x1, int x2, int x3, int ret, int cnt, int exc, int eid);
    vec_t v;
    v.rst = 1'(rst); v.dv = 4'(dv);
    v.cv0 = 1'(a0); v.ci0 = 5'(i0); v.ce0 = 1'(e0);
    v.cv1 = 1'(a1); v.ci1 = 5'(i1); v.ce1 = 1'(e1);
    v.fl = 1'(fl);
    v.id0 = 5'(x0); v.id1 = 5'(x1); v.id2 = 5'(x2); v.id3 = 5'(x3);
    v.ret = 4'(ret); v.cnt = 6'(cnt); v.exc = 1'(exc); v.exc_id = 5'(eid);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] dv, input logic a0, input logic [ID_W-1:0] i0, input logic e0,
                       input logic a1, input logic [ID_W-1:0] i1, input logic e1, input logic fl);
    @(negedge clock);
    dispatch_vld = dv;
    for (int k = 0; k < 4; k++) begin
      seq++;
      wd[k] = {8'hA5, 8'(seq), 32'($urandom())};
      if (dv[k] && !fl) sb.push_back(wd[k]);
    end
    cv0 = a0; ci0 = i0; ce0 = e0;
    cv1 = a1; ci1 = i1; ce1 = e1;
    flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(4'b0000, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    logic [EW-1:0] rd [4];
    @(posedge clock);
    #1;
    rd[0] = rd0; rd[1] = rd1; rd[2] = rd2; rd[3] = rd3;
    for (int k = 0; k < 4; k++) begin
      if (retire_vld[k]) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: retire slot %0d fired with no entry expected", k);
        end else begin
          chk("retire_data", 64'(rd[k]), 64'(sb.pop_front()));
        end
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [ID_W-1:0] ids [4];
    // rst dv  cv0 ci0 ce0 cv1 ci1 ce1 fl  ids........  ret cnt exc eid
    tbl[0]  = mk(0, 15, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 3,  0, 4, 0, 0);
    tbl[1]  = mk(1,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    tbl[2]  = mk(0,  7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2, 0,  0, 3, 0, 0);
    tbl[3]  = mk(0,  5, 0, 0, 0, 0, 0, 0, 0,  3, 0, 4, 0,  0, 5, 0, 0);
    tbl[4]  = mk(0,  0, 1, 1, 0, 1, 2, 0, 0,  0, 0, 0, 0,  0, 5, 0, 0);
    tbl[5]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 5, 0, 0);
    tbl[6]  = mk(0,  0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 5, 0, 0);
    tbl[7]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  7, 2, 0, 0);
    tbl[8]  = mk(0, 15, 1, 3, 0, 1, 4, 0, 0,  5, 6, 7, 8,  0, 6, 0, 0);
    tbl[9]  = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  3, 4, 0, 0);
    tbl[10] = mk(0,  0, 1, 5, 0, 1, 5, 1, 0,  0, 0, 0, 0,  0, 4, 0, 0);
    tbl[11] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 5);
    tbl[12] = mk(0,  3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  0, 2, 0, 0);
    tbl[13] = mk(0, 15, 1, 0, 0, 1, 1, 0, 1,  2, 3, 4, 5,  0, 0, 0, 0);
    tbl[14] = mk(0,  1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 0);
    tbl[15] = mk(0,  0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 0);
    tbl[16] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0);

    reset_n = 1'b0;
    dispatch_vld = '0; cv0 = 0; cv1 = 0; ce0 = 0; ce1 = 0; ci0 = '0; ci1 = '0; flush = 0;
    for (int k = 0; k < 4; k++) wd[k] = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_retire_vld", 64'(retire_vld), 64'd0);
    chk("rst_cnt", 64'(rob_cnt), 64'd0);
    chk("rst_exc", 64'(rob_exc), 64'd0);
    chk("rst_exc_id", 64'(rob_exc_id), 64'd0);
    chk("rst_data0", 64'(rd0), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int r = 0; r < NV; r++) begin
      v = tbl[r];
      if (v.rst) begin
        @(negedge clock);
        dispatch_vld = '0; cv0 = 0; cv1 = 0; flush = 0;
        reset_n = 1'b0;
        #1;
        chk("midrst_cnt", 64'(rob_cnt), 64'(v.cnt));
        chk("midrst_ret", 64'(retire_vld), 64'(v.ret));
        chk("midrst_id0", 64'(aid0), 64'(v.id0));
        sb.delete();
        #1 reset_n = 1'b1;
      end else begin
        drive(v.dv, v.cv0, v.ci0, v.ce0, v.cv1, v.ci1, v.ce1, v.fl);
        ids[0] = aid0; ids[1] = aid1; ids[2] = aid2; ids[3] = aid3;
        if (v.dv[0]) chk("alloc_id0", 64'(ids[0]), 64'(v.id0));
        if (v.dv[1]) chk("alloc_id1", 64'(ids[1]), 64'(v.id1));
        if (v.dv[2]) chk("alloc_id2", 64'(ids[2]), 64'(v.id2));
        if (v.dv[3]) chk("alloc_id3", 64'(ids[3]), 64'(v.id3));
        tick();
        chk("retire_vld", 64'(retire_vld), 64'(v.ret));
        chk("rob_cnt", 64'(rob_cnt), 64'(v.cnt));
        chk("rob_exc", 64'(rob_exc), 64'(v.exc));
        if (v.exc) chk("rob_exc_id", 64'(rob_exc_id), 64'(v.exc_id));
        if (v.exc || v.fl) sb.delete();
      end
    end

    // Walk head and tail from 1 up to 26 with everything retiring behind them
    tail_m = 1;
    nc = 1;
    for (int c = 0; c < 40; c++) begin
      logic [3:0] dv;
      logic       a0, a1;
      int         room;
      if (tail_m >= 26 && nc >= 26) break;
      room = 26 - tail_m;
      dv = (room >= 4) ? 4'b1111 : 4'((1 << room) - 1);
      a0 = nc < tail_m;
      a1 = (nc + 1) < tail_m;
      drive(dv, a0, 5'(nc), 1'b0, a1, 5'(nc + 1), 1'b0, 1'b0);
      if (dv != 4'b0000) chk("fill_alloc_id0", 64'(aid0), 64'(tail_m));
      tick();
      tail_m += $countones(dv);
      nc += int'(a0) + int'(a1);
    end
    for (int c = 0; c < 20 && rob_cnt != 0; c++) begin
      idle();
      tick();
    end
    chk("drain_cnt", 64'(rob_cnt), 64'd0);
    chk("drain_sb_left", 64'(sb.size()), 64'd0);

    // Allocate 26..29, complete out of order so none retires early
    drive(4'b1111, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("w_id0", 64'(aid0), 64'd26);
    chk("w_id3", 64'(aid3), 64'd29);
    tick();
    chk("w_cnt4", 64'(rob_cnt), 64'd4);
    drive(4'b0000, 1'b1, 5'd27, 1'b0, 1'b1, 5'd28, 1'b0, 1'b0);
    tick();
    chk("w_hold1", 64'(retire_vld), 64'd0);
    drive(4'b0000, 1'b1, 5'd26, 1'b0, 1'b1, 5'd29, 1'b0, 1'b0);
    tick();
    chk("w_hold2", 64'(retire_vld), 64'd0);
    // Allocation straddles the wrap while four retire in the same cycle
    drive(4'b1111, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("wrap_id0", 64'(aid0), 64'd30);
    chk("wrap_id1", 64'(aid1), 64'd31);
    chk("wrap_id2", 64'(aid2), 64'd0);
    chk("wrap_id3", 64'(aid3), 64'd1);
    tick();
    chk("wrap_ret4", 64'(retire_vld), 64'hF);
    chk("wrap_cnt_same", 64'(rob_cnt), 64'd4);
    drive(4'b0000, 1'b1, 5'd31, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    chk("wrap_hold", 64'(retire_vld), 64'd0);
    drive(4'b0000, 1'b1, 5'd30, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
    tick();
    chk("wrap_hold2", 64'(retire_vld), 64'd0);
    idle();
    tick();
    chk("wrap_retire", 64'(retire_vld), 64'hF);
    chk("wrap_cnt0", 64'(rob_cnt), 64'd0);
    chk("final_sb_left", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
endmodule
